// File: rtl/plot_scheduler_pkg.sv
// plot_scheduler_pkg -- shared definitions for the plot scheduler slice.
//   Arena bounds and colour defaults, the scheduler state enum, the
//   head-coordinate struct and small coordinate helpers.
package plot_scheduler_pkg;

    localparam logic [7:0] ARENA_X_MIN = 8'd11;
    localparam logic [7:0] ARENA_X_MAX = 8'd148;
    localparam logic [6:0] ARENA_Y_MIN = 7'd18;
    localparam logic [6:0] ARENA_Y_MAX = 7'd107;

    localparam logic [2:0] COL_P1 = 3'b001;
    localparam logic [2:0] COL_P2 = 3'b100;
    localparam logic [2:0] COL_BG = 3'b000;

    // Full frame held by the occupancy board
    localparam int BOARD_W = 160;
    localparam int BOARD_H = 120;

    typedef enum logic [2:0] {
        CLEAR, IDLE, RD1, CHK1, RD2, CHK2, DEAD
    } state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } head_t;

    // Inclusive rectangle test
    function automatic logic in_box(input head_t h,
                                    input logic [7:0] x_lo, input logic [7:0] x_hi,
                                    input logic [6:0] y_lo, input logic [6:0] y_hi);
        return (h.x >= x_lo) && (h.x <= x_hi) && (h.y >= y_lo) && (h.y <= y_hi);
    endfunction

    // Coordinate lies inside the physical board storage
    function automatic logic on_board(input head_t h);
        return (h.x < 8'(BOARD_W)) && (h.y < 7'(BOARD_H));
    endfunction

endpackage

// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if -- game-side bus of the plot scheduler.
//   master: game logic (drives tick, clear_req, head coordinates;
//           observes the pixel-write port and status).
//   slave : plot_scheduler.
interface plot_scheduler_if;
    logic       tick;
    logic       clear_req;
    logic [7:0] p1_x;
    logic [6:0] p1_y;
    logic [7:0] p2_x;
    logic [6:0] p2_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       p1_dead;
    logic       p2_dead;
    logic       busy;
    logic       clear_done;

    modport master (
        output tick, clear_req, p1_x, p1_y, p2_x, p2_y,
        input  vga_x, vga_y, vga_colour, vga_plot, p1_dead, p2_dead, busy, clear_done
    );

    modport slave (
        input  tick, clear_req, p1_x, p1_y, p2_x, p2_y,
        output vga_x, vga_y, vga_colour, vga_plot, p1_dead, p2_dead, busy, clear_done
    );
endinterface

// File: rtl/plot_scheduler_occupancy_ram.sv
// occupancy_ram -- 160x120x1 occupancy board.
//   CLOCK_50 : clock
//   rd_addr  : read coordinate, data returned on rd_data one cycle later
//   wr_en/wr_addr/wr_data : single write port
// Coordinates outside the board read as 0 and writes to them are dropped.
module occupancy_ram
    import plot_scheduler_pkg::*;
(
    input  logic  CLOCK_50,
    input  head_t rd_addr,
    output logic  rd_data,
    input  logic  wr_en,
    input  head_t wr_addr,
    input  logic  wr_data
);

    logic mem [BOARD_W][BOARD_H];
    logic rd_data_q;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en && on_board(wr_addr))
            mem[wr_addr.x][wr_addr.y] <= wr_data;
        rd_data_q <= on_board(rd_addr) ? mem[rd_addr.x][rd_addr.y] : 1'b0;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler -- per-tick collision check and pixel scheduling for a
// two-player light-cycle arena.
//   CLOCK_50 : clock, rising edge
//   resetn   : synchronous active-low reset
//   bus      : plot_scheduler_if.slave
//              in : tick, clear_req, p1_x/p1_y, p2_x/p2_y
//              out: vga_x/vga_y/vga_colour/vga_plot (registered),
//                   p1_dead/p2_dead (sticky), busy, clear_done (pulse)
// Each step reads the board for P1 then P2; P2's read follows P1's write,
// so P2 sees this step's P1 pixel. A clear sweep wipes the arena.
module plot_scheduler
    import plot_scheduler_pkg::*;
#(
    parameter logic [7:0] X_MIN     = ARENA_X_MIN,
    parameter logic [7:0] X_MAX     = ARENA_X_MAX,
    parameter logic [6:0] Y_MIN     = ARENA_Y_MIN,
    parameter logic [6:0] Y_MAX     = ARENA_Y_MAX,
    parameter logic [2:0] P1_COLOUR = COL_P1,
    parameter logic [2:0] P2_COLOUR = COL_P2,
    parameter logic [2:0] BG_COLOUR = COL_BG
) (
    input logic              CLOCK_50,
    input logic              resetn,
    plot_scheduler_if.slave  bus
);

    state_e     state_q, state_d;
    head_t      h1_q, h1_d, h2_q, h2_d;
    logic [7:0] sx_q, sx_d;
    logic [6:0] sy_q, sy_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_col_q, vga_col_d;
    logic       vga_plot_q, vga_plot_d;
    logic       p1_dead_q, p1_dead_d;
    logic       p2_dead_q, p2_dead_d;
    logic       clear_done_q, clear_done_d;

    head_t rd_addr, wr_addr;
    logic  rd_data, wr_en, wr_data;
    logic  kill1, kill2;

    occupancy_ram u_board (
        .CLOCK_50 (CLOCK_50),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= CLEAR;
            h1_q         <= '0;
            h2_q         <= '0;
            sx_q         <= X_MIN;
            sy_q         <= Y_MIN;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            vga_plot_q   <= 1'b0;
            p1_dead_q    <= 1'b0;
            p2_dead_q    <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_col_q    <= vga_col_d;
            vga_plot_q   <= vga_plot_d;
            p1_dead_q    <= p1_dead_d;
            p2_dead_q    <= p2_dead_d;
            clear_done_q <= clear_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_col_d    = vga_col_q;
        vga_plot_d   = 1'b0;
        p1_dead_d    = p1_dead_q;
        p2_dead_d    = p2_dead_q;
        clear_done_d = 1'b0;
        rd_addr      = h1_q;
        wr_en        = 1'b0;
        wr_addr      = h1_q;
        wr_data      = 1'b1;

        // rd_data is only meaningful in CHK1/CHK2, one cycle after RD1/RD2
        kill1 = rd_data || !in_box(h1_q, X_MIN, X_MAX, Y_MIN, Y_MAX) || (h1_q == h2_q);
        kill2 = rd_data || !in_box(h2_q, X_MIN, X_MAX, Y_MIN, Y_MAX) || (h1_q == h2_q);

        case (state_q)
            CLEAR: begin
                vga_plot_d = 1'b1;
                vga_x_d    = sx_q;
                vga_y_d    = sy_q;
                vga_col_d  = BG_COLOUR;
                wr_en      = 1'b1;
                wr_addr    = {sx_q, sy_q};
                wr_data    = 1'b0;
                // column-major walk: y fastest
                if (sy_q == Y_MAX) begin
                    sy_d = Y_MIN;
                    if (sx_q == X_MAX) begin
                        sx_d         = X_MIN;
                        p1_dead_d    = 1'b0;
                        p2_dead_d    = 1'b0;
                        clear_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        sx_d = sx_q + 8'd1;
                    end
                end else begin
                    sy_d = sy_q + 7'd1;
                end
            end
            IDLE: begin
                if (bus.tick) begin
                    h1_d    = {bus.p1_x, bus.p1_y};
                    h2_d    = {bus.p2_x, bus.p2_y};
                    state_d = RD1;
                end
            end
            RD1: begin
                rd_addr = h1_q;
                state_d = CHK1;
            end
            CHK1: begin
                if (kill1) begin
                    p1_dead_d = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = h1_q;
                    vga_plot_d = 1'b1;
                    vga_x_d    = h1_q.x;
                    vga_y_d    = h1_q.y;
                    vga_col_d  = P1_COLOUR;
                end
                state_d = RD2;
            end
            RD2: begin
                rd_addr = h2_q;
                state_d = CHK2;
            end
            CHK2: begin
                if (kill2) begin
                    p2_dead_d = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = h2_q;
                    vga_plot_d = 1'b1;
                    vga_x_d    = h2_q.x;
                    vga_y_d    = h2_q.y;
                    vga_col_d  = P2_COLOUR;
                end
                state_d = (p1_dead_q || kill2) ? DEAD : IDLE;
            end
            DEAD: ;
            default: state_d = CLEAR;
        endcase

        // A clear request abandons whatever step is in flight: nothing from
        // this cycle is plotted, written or flagged, and the sweep restarts.
        if (bus.clear_req && state_q != CLEAR) begin
            state_d      = CLEAR;
            h1_d         = h1_q;
            h2_d         = h2_q;
            sx_d         = X_MIN;
            sy_d         = Y_MIN;
            vga_x_d      = vga_x_q;
            vga_y_d      = vga_y_q;
            vga_col_d    = vga_col_q;
            vga_plot_d   = 1'b0;
            p1_dead_d    = p1_dead_q;
            p2_dead_d    = p2_dead_q;
            clear_done_d = 1'b0;
            wr_en        = 1'b0;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.p1_dead    = p1_dead_q;
    assign bus.p2_dead    = p2_dead_q;
    assign bus.clear_done = clear_done_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler -- scoreboard bench for plot_scheduler.
// Stimulus pushes expected pixels (with the cycle they must appear in)
// into a queue; a negedge monitor pops and compares on every vga_plot.
module tb_plot_scheduler;
    import plot_scheduler_pkg::*;

    localparam int XMN = 11, XMX = 148, YMN = 18, YMX = 107;

    logic CLOCK_50 = 1'b0;
    logic resetn   = 1'b0;

    plot_scheduler_if bus();

    plot_scheduler dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int col;
        int cyc;
        bit last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   board [160][120];
    bit   m_p1d, m_p2d;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLOCK_50) begin
        if (resetn) begin
            if (bus.vga_plot) begin
                if (q.size() == 0) begin
                    check("unexpected_plot", int'(bus.vga_plot), 0);
                end else begin
                    e = q.pop_front();
                    check("plot_x", int'(bus.vga_x), e.x);
                    check("plot_y", int'(bus.vga_y), e.y);
                    check("plot_colour", int'(bus.vga_colour), e.col);
                    check("plot_cycle", cyc, e.cyc);
                    check("clear_done_on_plot", int'(bus.clear_done), int'(e.last));
                end
            end else begin
                check("clear_done_noplot", int'(bus.clear_done), 0);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit in_arena(input int x, input int y);
        return x >= XMN && x <= XMX && y >= YMN && y <= YMX;
    endfunction

    function automatic bit occupied(input int x, input int y);
        return in_arena(x, y) ? board[x][y] : 1'b0;
    endfunction

    // c: cycle at which the tick is driven; plots land 3 and 5 cycles later
    task automatic model_step(input int x1, input int y1, input int x2, input int y2, input int c);
        bit k1, k2, eq;
        if (m_p1d || m_p2d) return;
        eq = (x1 == x2) && (y1 == y2);
        k1 = !in_arena(x1, y1) || occupied(x1, y1) || eq;
        if (k1) m_p1d = 1'b1;
        else begin
            board[x1][y1] = 1'b1;
            q.push_back('{x: x1, y: y1, col: 1, cyc: c + 3, last: 1'b0});
        end
        k2 = !in_arena(x2, y2) || occupied(x2, y2) || eq;
        if (k2) m_p2d = 1'b1;
        else begin
            board[x2][y2] = 1'b1;
            q.push_back('{x: x2, y: y2, col: 4, cyc: c + 5, last: 1'b0});
        end
    endtask

    task automatic push_sweep(input int c0);
        int i = 0;
        for (int x = XMN; x <= XMX; x++)
            for (int y = YMN; y <= YMX; y++) begin
                q.push_back('{x: x, y: y, col: 0, cyc: c0 + i,
                              last: (x == XMX && y == YMX)});
                i++;
            end
    endtask

    task automatic model_clear();
        for (int x = 0; x < 160; x++)
            for (int y = 0; y < 120; y++)
                board[x][y] = 1'b0;
        m_p1d = 1'b0;
        m_p2d = 1'b0;
    endtask

    // ---------------- stimulus helpers ----------------
    // Waits for clear_done; injects an ignored tick and clear_req mid-sweep.
    task automatic wait_clear(input string name);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 13000) begin
            @(negedge CLOCK_50);
            n++;
            if (bus.clear_done) done = 1;
            if (n == 100) begin
                bus.p1_x = 8'd40; bus.p1_y = 7'd40; bus.p2_x = 8'd50; bus.p2_y = 7'd50;
                bus.tick = 1'b1;
            end
            if (n == 101) bus.tick = 1'b0;
            if (n == 400) bus.clear_req = 1'b1;
            if (n == 401) bus.clear_req = 1'b0;
        end
        check({name, "_done_seen"}, int'(done), 1);
        check({name, "_busy_low"}, int'(bus.busy), 0);
        model_clear();
        @(negedge CLOCK_50);
        check({name, "_queue_drained"}, q.size(), 0);
        check({name, "_p1_dead_clr"}, int'(bus.p1_dead), 0);
        check({name, "_p2_dead_clr"}, int'(bus.p2_dead), 0);
    endtask

    task automatic do_clear(input string name);
        @(negedge CLOCK_50);
        push_sweep(cyc + 2);
        bus.clear_req = 1'b1;
        @(negedge CLOCK_50);
        bus.clear_req = 1'b0;
        wait_clear(name);
    endtask

    task automatic do_step(input string name, input int x1, input int y1,
                           input int x2, input int y2, input bit hold);
        @(negedge CLOCK_50);
        bus.p1_x = 8'(x1); bus.p1_y = 7'(y1);
        bus.p2_x = 8'(x2); bus.p2_y = 7'(y2);
        bus.tick = 1'b1;
        model_step(x1, y1, x2, y2, cyc);
        @(negedge CLOCK_50);
        // heads are latched at the tick; moving them now must not matter
        bus.p1_x = 8'(x2); bus.p1_y = 7'(y2);
        bus.p2_x = 8'(x1); bus.p2_y = 7'(y1);
        if (!hold) bus.tick = 1'b0;
        @(negedge CLOCK_50);
        bus.tick = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        check({name, "_p1_dead"}, int'(bus.p1_dead), int'(m_p1d));
        check({name, "_p2_dead"}, int'(bus.p2_dead), int'(m_p2d));
        check({name, "_busy"}, int'(bus.busy), int'(m_p1d || m_p2d));
        check({name, "_queue_drained"}, q.size(), 0);
    endtask

    initial begin
        #2_500_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int x1, y1, x2, y2;
        bus.tick = 1'b0; bus.clear_req = 1'b0;
        bus.p1_x = '0; bus.p1_y = '0; bus.p2_x = '0; bus.p2_y = '0;
        m_p1d = 1'b0; m_p2d = 1'b0;

        // reset state
        repeat (3) @(negedge CLOCK_50);
        check("rst_vga_plot", int'(bus.vga_plot), 0);
        check("rst_vga_x", int'(bus.vga_x), 0);
        check("rst_vga_y", int'(bus.vga_y), 0);
        check("rst_vga_colour", int'(bus.vga_colour), 0);
        check("rst_p1_dead", int'(bus.p1_dead), 0);
        check("rst_p2_dead", int'(bus.p2_dead), 0);
        check("rst_clear_done", int'(bus.clear_done), 0);
        check("rst_busy", int'(bus.busy), 1);
        push_sweep(cyc + 1);
        resetn = 1'b1;
        wait_clear("reset_sweep");

        do_step("two_heads", 25, 100, 135, 100, 1'b0);
        do_step("repeat_heads", 25, 100, 135, 100, 1'b0);
        do_step("tick_in_dead", 60, 60, 70, 70, 1'b0);
        do_clear("clear_from_dead");

        // clear_req sampled at E1 of a step: sweep replaces the P1 plot slot
        @(negedge CLOCK_50);
        bus.p1_x = 8'd30; bus.p1_y = 7'd30; bus.p2_x = 8'd90; bus.p2_y = 7'd90;
        bus.tick = 1'b1;
        @(negedge CLOCK_50);
        bus.tick = 1'b0;
        bus.clear_req = 1'b1;
        push_sweep(cyc + 2);
        @(negedge CLOCK_50);
        bus.clear_req = 1'b0;
        wait_clear("clear_mid_step");

        do_step("p1_left_oob", 10, 50, 60, 60, 1'b0);
        do_clear("clear_after_oob");
        do_step("head_on", 80, 80, 80, 80, 1'b0);
        do_clear("clear_after_headon");

        for (int i = 0; i < 60; i++) begin
            x1 = $urandom_range(10, 149); y1 = $urandom_range(17, 108);
            x2 = $urandom_range(10, 149); y2 = $urandom_range(17, 108);
            if ($urandom_range(0, 7) == 0) x1 = ($urandom_range(0, 1) == 0) ? XMN : XMX;
            if ($urandom_range(0, 7) == 0) y2 = ($urandom_range(0, 1) == 0) ? YMN : YMX;
            if ($urandom_range(0, 19) == 0) begin x2 = x1; y2 = y1; end
            do_step("random", x1, y1, x2, y2, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_scheduler.md
PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 Parameter X_MIN, default 11, leftmost playable column.
REQ-002 Parameter X_MAX, default 148, rightmost playable column.
REQ-003 Parameter Y_MIN, default 18, top playable row.
REQ-004 Parameter Y_MAX, default 107, bottom playable row.
REQ-005 Parameters P1_COLOUR = 3'b001, P2_COLOUR = 3'b100, BG_COLOUR = 3'b000 SHALL set the plot colours.
REQ-006 Port CLOCK_50, in, 1, system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Port resetn, in, 1, reset: synchronous, active-low.
REQ-008 Port tick, in, 1, one-cycle game-step pulse.
REQ-009 Port clear_req, in, 1, level or pulse requesting an arena wipe.
REQ-010 Ports p1_x (in, 8), p1_y (in, 7), p2_x (in, 8), p2_y (in, 7): head coordinates of each player.
REQ-011 Ports vga_x (out, 8), vga_y (out, 7), vga_colour (out, 3), vga_plot (out, 1): pixel-write port, all registered.
REQ-012 Ports p1_dead (out, 1) and p2_dead (out, 1): sticky death flags.
REQ-013 Port busy (out, 1): high whenever the state is not IDLE.
REQ-014 Port clear_done (out, 1): one-cycle pulse on completion of a sweep.

Function
REQ-015 States: CLEAR, IDLE, RD1, CHK1, RD2, CHK2, DEAD.
REQ-016 Occupancy board: 160x120 bits, one bit per pixel, synchronous read with 1-cycle latency, one write port.
REQ-017 IDLE with tick=1 and clear_req=0 SHALL latch all four head coordinates and go to RD1, which issues the P1 board read.
REQ-018 CHK1 kill conditions: board bit set, p1_x outside [X_MIN, X_MAX], p1_y outside [Y_MIN, Y_MAX], or P1 head equal to P2 head.
  - Killed: set p1_dead, no plot.
  - Otherwise: set the board bit, and vga_plot=1 for exactly one cycle with P1_COLOUR.
REQ-019 RD2 and CHK2 SHALL apply the same rules to P2. P2 is always evaluated, even if P1 died this step, and the board read sees P1's write from this step.
REQ-020 Head-on collision (equal heads) SHALL set both dead flags in the same step.
REQ-021 Latency: with tick sampled at edge E0, the P1 plot SHALL be valid after E2 and the P2 plot after E4; vga_plot SHALL be 0 in all other non-CLEAR cycles.
REQ-022 After CHK2: go to DEAD if either flag is set, else IDLE.
REQ-023 tick in any state other than IDLE SHALL be ignored (dropped, not queued).
REQ-024 clear_req sampled high in any state except CLEAR SHALL force CLEAR on the next edge, abandoning any step in progress.
  - clear_req in CLEAR is ignored.
  - clear_req has priority over a simultaneous tick.
REQ-025 CLEAR sweep: x outer, y inner, from (X_MIN, Y_MIN) to (X_MAX, Y_MAX), one pixel per cycle.
  - Each cycle: vga_plot=1, BG_COLOUR, board bit cleared.
  - Total 138*90 = 12420 plot cycles.
REQ-026 On the last sweep pixel: clear both dead flags, pulse clear_done, go to IDLE.
REQ-027 DEAD SHALL hold until clear_req arrives, with vga_plot=0 and both flags stable.

Reset
REQ-028 resetn=0 on a clock edge SHALL give: state CLEAR, sweep counters at (X_MIN, Y_MIN), vga_plot=0, vga_x/vga_y/vga_colour=0, p1_dead=p2_dead=0, clear_done=0.
REQ-029 After reset release, a full sweep SHALL run before the first tick is accepted; board contents are not reset directly.

Structure
REQ-030 A shared package SHALL hold the arena bounds, the colour constants and the state enum.
REQ-031 The board SHALL be the sub-module occupancy_ram (160x120x1, sync read, single write port).

Verification
REQ-032 Reset, then wait: exactly 12420 plots of 3'b000 over (11..148, 18..107), then clear_done=1 for 1 cycle and busy=0.
REQ-033 Heads (25,100) and (135,100), one tick: plot (25,100) colour 001 after E2, plot (135,100) colour 100 after E4, no dead flags.
REQ-034 Repeat the same heads on a second tick: p1_dead=1 and p2_dead=1, no plots, state DEAD, busy=1.
REQ-035 P1 head at (10,50), P2 head at (60,60): p1_dead=1 only, P2 plotted at (60,60).
REQ-036 Both heads at (80,80): both flags set, zero plots.
REQ-037 clear_req asserted at E1 of a step: no P1/P2 plot, sweep starts next edge; tick during the sweep is ignored.
